// File: rtl/mcu_pkg.sv
// Shared definitions for the MCU load/store path.
//   lsu_state_t : load/store unit sequencer states.
//   MEM_DEPTH   : number of byte entries in the data memory.
//   RW_READ / RW_WRITE : encodings of the memory readWriteControl line.
package mcu_pkg;

    localparam int   MEM_DEPTH = 256;
    localparam logic RW_READ   = 1'b0;
    localparam logic RW_WRITE  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        RESP
    } lsu_state_t;

endpackage

// File: rtl/load_store_unit_if.sv
// Bus bundle between the execute stage, the load/store unit and the data memory.
//
// Request handshake: a request transfers on the rising edge where reqValid and
// reqReady are both high. reqReady is high only while the unit is idle; reqValid
// may stay high while reqReady is low and nothing is taken. The request fields
// (reqWrite, reqWide, reqAddress, reqWriteData) are only looked at on the
// transfer edge. Completion is a one-cycle respValid pulse with respData; there
// is no response backpressure.
//
// Memory side: memAddress / memWriteData / memReadWriteControl drive the byte
// memory, memReadData is its combinational read port.
//
// Modports:
//   slave  : the load/store unit.
//   master : the environment (execute stage plus data memory).
interface load_store_unit_if #(
    parameter int BUS_WIDTH  = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                   reqValid;
    logic                   reqReady;
    logic                   reqWrite;
    logic                   reqWide;
    logic [ADDR_WIDTH-1:0]  reqAddress;
    logic [2*BUS_WIDTH-1:0] reqWriteData;
    logic                   respValid;
    logic [2*BUS_WIDTH-1:0] respData;
    logic [ADDR_WIDTH-1:0]  memAddress;
    logic [BUS_WIDTH-1:0]   memWriteData;
    logic                   memReadWriteControl;
    logic [BUS_WIDTH-1:0]   memReadData;

    modport slave (
        input  reqValid, reqWrite, reqWide, reqAddress, reqWriteData, memReadData,
        output reqReady, respValid, respData, memAddress, memWriteData, memReadWriteControl
    );

    modport master (
        output reqValid, reqWrite, reqWide, reqAddress, reqWriteData, memReadData,
        input  reqReady, respValid, respData, memAddress, memWriteData, memReadWriteControl
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: sequences byte and 16-bit little-endian loads/stores into an
// 8-bit data memory, one request at a time, and drives the memory's
// level-sensitive write strobe with a registered setup/pulse/hold sequence.
//
// Ports:
//   clock     : rising-edge clock.
//   nReset    : asynchronous active-low reset.
//   bus       : load_store_unit_if.slave (request, response and memory signals).
//   lsu_state : current sequencer state, for observation.
module load_store_unit
    import mcu_pkg::*;
#(
    parameter int BUS_WIDTH  = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 nReset,
    load_store_unit_if.slave     bus,
    output lsu_state_t           lsu_state
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    lsu_state_t             state;
    logic                   hi_sel;     // 0: low byte in progress, 1: high byte
    logic                   is_wide;
    logic [ADDR_WIDTH-1:0]  base_addr;
    logic [2*BUS_WIDTH-1:0] store_data;
    logic [BUS_WIDTH-1:0]   load_lo;
    logic                   req_ready;
    logic                   resp_valid;
    logic [2*BUS_WIDTH-1:0] resp_data;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic [BUS_WIDTH-1:0]   mem_wdata;
    logic                   mem_rw;

    // Address and write data only ever change on edges where the strobe stays
    // low (accept, WR_HOLD -> WR_SETUP, RD_LO -> RD_HI), so the memory never
    // sees them move around the write pulse.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state      <= IDLE;
            hi_sel     <= 1'b0;
            is_wide    <= 1'b0;
            base_addr  <= '0;
            store_data <= '0;
            load_lo    <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_rw     <= RW_READ;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.reqValid && req_ready) begin
                        base_addr  <= bus.reqAddress;
                        store_data <= bus.reqWriteData;
                        is_wide    <= bus.reqWide;
                        hi_sel     <= 1'b0;
                        mem_addr   <= bus.reqAddress;
                        req_ready  <= 1'b0;
                        if (bus.reqWrite) begin
                            mem_wdata <= bus.reqWriteData[BUS_WIDTH-1:0];
                            state     <= WR_SETUP;
                        end else begin
                            state     <= RD_LO;
                        end
                    end
                end
                RD_LO: begin
                    load_lo <= bus.memReadData;
                    if (is_wide) begin
                        mem_addr <= base_addr + ADDR_ONE;
                        state    <= RD_HI;
                    end else begin
                        resp_data  <= {{BUS_WIDTH{1'b0}}, bus.memReadData};
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RD_HI: begin
                    resp_data  <= {bus.memReadData, load_lo};
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                WR_SETUP: begin
                    mem_rw <= RW_WRITE;
                    state  <= WR_PULSE;
                end
                WR_PULSE: begin
                    mem_rw <= RW_READ;
                    state  <= WR_HOLD;
                end
                WR_HOLD: begin
                    if (is_wide && !hi_sel) begin
                        hi_sel    <= 1'b1;
                        mem_addr  <= base_addr + ADDR_ONE;
                        mem_wdata <= store_data[2*BUS_WIDTH-1:BUS_WIDTH];
                        state     <= WR_SETUP;
                    end else begin
                        resp_data  <= '0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    mem_rw    <= RW_READ;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.reqReady            = req_ready;
    assign bus.respValid           = resp_valid;
    assign bus.respData            = resp_data;
    assign bus.memAddress          = mem_addr;
    assign bus.memWriteData        = mem_wdata;
    assign bus.memReadWriteControl = mem_rw;
    assign lsu_state               = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit together with a byte-wide data memory model
// (combinational read, write while readWriteControl is high).
module tb_load_store_unit;
    import mcu_pkg::*;

    localparam int BW = 8;
    localparam int AW = 8;

    // ---------------- clock / reset ----------------
    logic       clock  = 1'b0;
    logic       nReset = 1'b0;
    lsu_state_t lsu_state;
    int         cyc    = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    load_store_unit_if #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW)) bus();

    load_store_unit #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
        .clock     (clock),
        .nReset    (nReset),
        .bus       (bus),
        .lsu_state (lsu_state)
    );

    // ---------------- data memory ----------------
    logic [7:0] mem [0:MEM_DEPTH-1] = '{default: 8'h00};
    always @(posedge clock) begin
        if (bus.memReadWriteControl == RW_WRITE) mem[bus.memAddress] <= bus.memWriteData;
    end
    assign bus.memReadData = mem[bus.memAddress];

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    int          exp_lat_q[$];
    int          acc_q[$];
    int          n_checks   = 0;
    int          n_pass     = 0;
    int          resp_count = 0;
    int          rw_run     = 0;
    logic [7:0]  setup_addr = '0;
    logic [7:0]  setup_data = '0;
    logic [15:0] mon_exp_data;
    int          mon_exp_lat;
    int          mon_acc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clock) begin
        if (nReset) begin
            if (acc_q.size() != 0) check("ready_low_while_busy", bus.reqReady, 1'b0);
            if (bus.reqValid && bus.reqReady) acc_q.push_back(cyc + 1);
            if (bus.respValid) begin
                resp_count++;
                check("resp_expected", exp_q.size() != 0 && acc_q.size() != 0, 1'b1);
                if (exp_q.size() != 0 && acc_q.size() != 0) begin
                    mon_exp_data = exp_q.pop_front();
                    mon_exp_lat  = exp_lat_q.pop_front();
                    mon_acc      = acc_q.pop_front();
                    check("resp_data", bus.respData, mon_exp_data);
                    check("latency", (cyc + 1) - mon_acc, mon_exp_lat);
                end
            end
            if (bus.memReadWriteControl == RW_WRITE) begin
                rw_run++;
                check("ready_low_in_pulse", bus.reqReady, 1'b0);
            end else if (rw_run != 0) begin
                check("rw_pulse_len", rw_run, 1);
                rw_run = 0;
            end
            if (lsu_state == WR_SETUP) begin
                setup_addr = bus.memAddress;
                setup_data = bus.memWriteData;
                check("rw_low_in_setup", bus.memReadWriteControl, RW_READ);
            end else if (lsu_state == WR_PULSE || lsu_state == WR_HOLD) begin
                check("addr_stable", bus.memAddress, setup_addr);
                check("data_stable", bus.memWriteData, setup_data);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_accept();
        int waited = 0;
        @(negedge clock);
        while (!bus.reqReady && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        check("accept_in_budget", bus.reqReady, 1'b1);
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic wr, input logic wide, input logic [7:0] addr,
                         input logic [15:0] wdata, input logic [15:0] exp_data,
                         input int exp_lat, input bit expect_resp);
        @(posedge clock);
        #1;
        bus.reqValid     = 1'b1;
        bus.reqWrite     = wr;
        bus.reqWide      = wide;
        bus.reqAddress   = addr;
        bus.reqWriteData = wdata;
        if (expect_resp) begin
            exp_q.push_back(exp_data);
            exp_lat_q.push_back(exp_lat);
        end
        wait_accept();
        bus.reqValid = 1'b0;
    endtask

    task automatic wait_done();
        int waited = 0;
        while ((exp_q.size() != 0 || acc_q.size() != 0) && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        check("drain_in_budget", exp_q.size() + acc_q.size(), 0);
        repeat (2) @(negedge clock);
    endtask

    // ---------------- stimulus ----------------
    logic [7:0]  held_addr [3] = '{8'h10, 8'h21, 8'h40};
    logic [15:0] held_exp  [3] = '{16'h00A5, 16'h00BE, 16'h00FE};
    int          rc;
    int          waited;

    initial begin
        bus.reqValid     = 1'b0;
        bus.reqWrite     = 1'b0;
        bus.reqWide      = 1'b0;
        bus.reqAddress   = '0;
        bus.reqWriteData = '0;
        nReset           = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_state", 32'(lsu_state), 32'(IDLE));
        check("rst_ready", bus.reqReady, 1'b1);
        check("rst_resp_valid", bus.respValid, 1'b0);
        check("rst_resp_data", bus.respData, 16'h0000);
        check("rst_mem_addr", bus.memAddress, 8'h00);
        check("rst_mem_wdata", bus.memWriteData, 8'h00);
        check("rst_rw", bus.memReadWriteControl, RW_READ);
        @(negedge clock);
        nReset = 1'b1;

        // Byte store then byte load.
        issue(1'b1, 1'b0, 8'h10, 16'h00A5, 16'h0000, 4, 1'b1); wait_done();
        check("mem_10", mem[8'h10], 8'hA5);
        issue(1'b0, 1'b0, 8'h10, 16'h0000, 16'h00A5, 2, 1'b1); wait_done();

        // Wide store then wide load.
        issue(1'b1, 1'b1, 8'h20, 16'hBEEF, 16'h0000, 7, 1'b1); wait_done();
        check("mem_20", mem[8'h20], 8'hEF);
        check("mem_21", mem[8'h21], 8'hBE);
        issue(1'b0, 1'b1, 8'h20, 16'h0000, 16'hBEEF, 3, 1'b1); wait_done();

        // Address wrap at the top of memory.
        issue(1'b1, 1'b1, 8'hFF, 16'h1234, 16'h0000, 7, 1'b1); wait_done();
        check("mem_ff", mem[8'hFF], 8'h34);
        check("mem_00", mem[8'h00], 8'h12);
        issue(1'b0, 1'b1, 8'hFF, 16'h0000, 16'h1234, 3, 1'b1); wait_done();

        // Byte store ignores upper data; byte load zero-extends.
        issue(1'b1, 1'b0, 8'h41, 16'h5577, 16'h0000, 4, 1'b1); wait_done();
        check("mem_41", mem[8'h41], 8'h77);
        check("mem_42", mem[8'h42], 8'h00);
        issue(1'b0, 1'b0, 8'h21, 16'h0000, 16'h00BE, 2, 1'b1); wait_done();

        // Reset in the first WR_HOLD of a wide store.
        rc = resp_count;
        issue(1'b1, 1'b1, 8'h40, 16'hCAFE, 16'h0000, 0, 1'b0);
        waited = 0;
        @(negedge clock);
        while (lsu_state != WR_HOLD && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        check("reached_wr_hold", 32'(lsu_state), 32'(WR_HOLD));
        #1;
        nReset = 1'b0;
        #1;
        check("mid_rst_rw", bus.memReadWriteControl, RW_READ);
        check("mid_rst_ready", bus.reqReady, 1'b1);
        check("mid_rst_resp_valid", bus.respValid, 1'b0);
        check("mid_rst_state", 32'(lsu_state), 32'(IDLE));
        acc_q.delete();
        rw_run = 0;
        @(negedge clock);
        nReset = 1'b1;
        repeat (10) @(negedge clock);
        check("mid_rst_no_resp", resp_count - rc, 0);
        check("mid_rst_mem_40", mem[8'h40], 8'hFE);
        check("mid_rst_mem_41", mem[8'h41], 8'h77);

        // reqValid held high across three byte loads.
        rc = resp_count;
        @(posedge clock);
        #1;
        bus.reqValid = 1'b1;
        bus.reqWrite = 1'b0;
        bus.reqWide  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.reqAddress = held_addr[i];
            exp_q.push_back(held_exp[i]);
            exp_lat_q.push_back(2);
            wait_accept();
        end
        bus.reqValid = 1'b0;
        wait_done();
        check("held_resp_count", resp_count - rc, 3);

        check("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
